control_unit: RTL and testbench



---
 rtl/control_unit_if.sv | 31 +++
 rtl/control_unit.sv | 174 +++++++++++++++++
 tb/tb_control_unit.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// control_unit_if: signal bundle between the Mini SRC control sequencer and
// its datapath. The master modport is the control unit. The slave modport
// is the datapath, which supplies IR, CON and the stop request.
interface control_unit_if;
  logic [31:0] ir;
  logic        CON_out;
  logic        stop;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        CON_in;
  logic        HIin, LOin, Zhighin, Zlowin, PCin, MDRin, OutPortin, MARin, IRin, Yin;
  logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, Inportout, Cout;
  logic        IncPC, read, write;
  logic [4:0]  operation;
  logic        run;

  modport master (
    input  ir, CON_out, stop,
    output Gra, Grb, Grc, Rin, Rout, BAout, CON_in,
           HIin, LOin, Zhighin, Zlowin, PCin, MDRin, OutPortin, MARin, IRin, Yin,
           HIout, LOout, ZHIout, ZLOout, PCout, MDRout, Inportout, Cout,
           IncPC, read, write, operation, run
  );

  modport slave (
    output ir, CON_out, stop,
    input  Gra, Grb, Grc, Rin, Rout, BAout, CON_in,
           HIin, LOin, Zhighin, Zlowin, PCin, MDRin, OutPortin, MARin, IRin, Yin,
           HIout, LOout, ZHIout, ZLOout, PCout, MDRout, Inportout, Cout,
           IncPC, read, write, operation, run
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the Mini SRC CPU.
// It runs four fetch states and up to six execute states, then a one-cycle
// DONE boundary where a stop request diverts the sequencer into PAUSE.
// Optional feature macro CU_SINGLE_STEP_EN adds a 'step' input. When the
// macro is defined, every instruction ends in PAUSE and a rising edge on
// step releases exactly one further instruction.
module control_unit (
  input  logic           clock,
  input  logic           clear,
`ifdef CU_SINGLE_STEP_EN
  input  logic           step,
`endif
  control_unit_if.master cu
);

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_F3,
    S_E0, S_E1, S_E2, S_E3, S_E4, S_E5,
    S_DONE, S_PAUSE, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3,  OP_SHL  = 5'd11, OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd14, OP_DIV  = 5'd15, OP_MUL  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17, OP_NOT  = 5'd18, OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20, OP_JAL  = 5'd21, OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26, OP_HALT = 5'd27, OP_RSV  = 5'd28;

  state_t     r_state, w_next;
  logic [4:0] w_op;
  logic [2:0] w_last;
  logic       w_alu_r, w_imm, w_muldiv, w_negnot, w_mem, w_nop;
  logic       w_unused_ir;

  // Index of the final execute state for each opcode. Opcodes that need only
  // E0 (including halt) return 0.
  function automatic logic [2:0] last_e(input logic [4:0] op);
    logic [2:0] n;
    n = 3'd0;
    if (op == OP_LD)                                    n = 3'd5;
    else if (op == OP_ST)                               n = 3'd4;
    else if (op == OP_LDI || (op >= OP_ADD && op <= OP_ORI)) n = 3'd2;
    else if (op == OP_DIV || op == OP_MUL || op == OP_BR)    n = 3'd3;
    else if (op == OP_NEG || op == OP_NOT || op == OP_JAL)   n = 3'd1;
    return n;
  endfunction

  assign w_op        = cu.ir[31:27];
  assign w_unused_ir = ^cu.ir[26:0];
  assign w_last      = last_e(w_op);
  assign w_alu_r     = (w_op >= OP_ADD) && (w_op <= OP_SHL);
  assign w_imm       = (w_op >= OP_ADDI) && (w_op <= OP_ORI);
  assign w_muldiv    = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_negnot    = (w_op == OP_NEG) || (w_op == OP_NOT);
  assign w_mem       = (w_op <= OP_ST);
  assign w_nop       = (w_op == OP_NOP) || (w_op >= OP_RSV);

`ifdef CU_SINGLE_STEP_EN
  logic r_step_q;
  logic w_step_rise;

  // Delay step by one cycle so a held level produces a single rising edge.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_step_q <= 1'b0;
    else        r_step_q <= step;
  end

  assign w_step_rise = step & ~r_step_q;
`endif

  // State register; an asserted clear forces RST immediately.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_RST;
    else        r_state <= w_next;
  end

  // Next-state sequencing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST:   w_next = S_F0;
      S_F0:    w_next = S_F1;
      S_F1:    w_next = S_F2;
      S_F2:    w_next = S_F3;
      S_F3:    w_next = w_nop ? S_DONE : S_E0;
      S_E0:    w_next = (w_op == OP_HALT) ? S_HALT :
                        (w_last == 3'd0)  ? S_DONE : S_E1;
      S_E1:    w_next = (w_last == 3'd1) ? S_DONE : S_E2;
      S_E2:    w_next = (w_last == 3'd2) ? S_DONE : S_E3;
      S_E3:    w_next = (w_last == 3'd3) ? S_DONE : S_E4;
      S_E4:    w_next = (w_last == 3'd4) ? S_DONE : S_E5;
      S_E5:    w_next = S_DONE;
`ifdef CU_SINGLE_STEP_EN
      S_DONE:  w_next = S_PAUSE;
      S_PAUSE: w_next = (w_step_rise && !cu.stop) ? S_F0 : S_PAUSE;
`else
      S_DONE:  w_next = cu.stop ? S_PAUSE : S_F0;
      S_PAUSE: w_next = cu.stop ? S_PAUSE : S_F0;
`endif
      S_HALT:  w_next = S_HALT;
      default: w_next = S_RST;
    endcase
  end

  // Moore output decode from state, opcode and the branch condition.
  always_comb begin
    {cu.Gra, cu.Grb, cu.Grc, cu.Rin, cu.Rout, cu.BAout, cu.CON_in,
     cu.HIin, cu.LOin, cu.Zhighin, cu.Zlowin, cu.PCin, cu.MDRin, cu.OutPortin,
     cu.MARin, cu.IRin, cu.Yin, cu.HIout, cu.LOout, cu.ZHIout, cu.ZLOout,
     cu.PCout, cu.MDRout, cu.Inportout, cu.Cout, cu.IncPC, cu.read,
     cu.write} = '0;
    cu.operation = 5'd0;
    cu.run = !((r_state == S_RST) || (r_state == S_PAUSE) || (r_state == S_HALT));
    case (r_state)
      S_F0: begin cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; end
      S_F1: cu.read = 1'b1;
      S_F2: begin cu.read = 1'b1; cu.MDRin = 1'b1; end
      S_F3: begin cu.MDRout = 1'b1; cu.IRin = 1'b1; end
      S_E0: begin
        if (w_alu_r || w_imm) begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
        else if (w_muldiv) begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
        else if (w_negnot) begin
          cu.Grb = 1'b1; cu.Rout = 1'b1; cu.operation = w_op; cu.Zlowin = 1'b1;
        end
        else if (w_mem) begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1; end
        else if (w_op == OP_BR) begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CON_in = 1'b1; end
        else if (w_op == OP_JR) begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
        else if (w_op == OP_JAL) begin cu.PCout = 1'b1; cu.Grb = 1'b1; cu.Rin = 1'b1; end
        else if (w_op == OP_IN) begin cu.Inportout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
        else if (w_op == OP_OUT) begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.OutPortin = 1'b1; end
        else if (w_op == OP_MFHI) begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
        else if (w_op == OP_MFLO) begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
      end
      S_E1: begin
        if (w_alu_r) begin
          cu.Grc = 1'b1; cu.Rout = 1'b1; cu.operation = w_op; cu.Zlowin = 1'b1;
        end
        else if (w_imm) begin cu.Cout = 1'b1; cu.operation = w_op; cu.Zlowin = 1'b1; end
        else if (w_muldiv) begin
          cu.Grb = 1'b1; cu.Rout = 1'b1; cu.operation = w_op;
          cu.Zhighin = 1'b1; cu.Zlowin = 1'b1;
        end
        else if (w_negnot) begin cu.ZLOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
        else if (w_mem) begin cu.Cout = 1'b1; cu.operation = OP_ADD; cu.Zlowin = 1'b1; end
        else if (w_op == OP_BR) begin cu.PCout = 1'b1; cu.Yin = 1'b1; end
        else if (w_op == OP_JAL) begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
      end
      S_E2: begin
        if (w_alu_r || w_imm || w_op == OP_LDI) begin
          cu.ZLOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1;
        end
        else if (w_muldiv) begin cu.ZLOout = 1'b1; cu.LOin = 1'b1; end
        else if (w_mem) begin cu.ZLOout = 1'b1; cu.MARin = 1'b1; end
        else if (w_op == OP_BR) begin cu.Cout = 1'b1; cu.operation = OP_ADD; cu.Zlowin = 1'b1; end
      end
      S_E3: begin
        if (w_muldiv) begin cu.ZHIout = 1'b1; cu.HIin = 1'b1; end
        else if (w_op == OP_LD) cu.read = 1'b1;
        else if (w_op == OP_ST) begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1; end
        else if (w_op == OP_BR && cu.CON_out) begin cu.ZLOout = 1'b1; cu.PCin = 1'b1; end
      end
      S_E4: begin
        if (w_op == OP_LD) begin cu.read = 1'b1; cu.MDRin = 1'b1; end
        else if (w_op == OP_ST) cu.write = 1'b1;
      end
      S_E5: begin
        if (w_op == OP_LD) begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench for the Mini SRC control sequencer.
// All observed outputs are packed into one word so that each cycle can be
// compared against a hand-built expected word.
module tb_control_unit;

  logic clock = 1'b0;
  logic clear = 1'b0;
`ifdef CU_SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  int checks = 0;
  int failures = 0;

  control_unit_if bus_if();

  control_unit dut (
    .clock (clock),
    .clear (clear),
`ifdef CU_SINGLE_STEP_EN
    .step  (step),
`endif
    .cu    (bus_if)
  );

  always #5 clock = ~clock;

  logic [33:0] w_obs;
  assign w_obs = {bus_if.operation, bus_if.run,
                  bus_if.Gra, bus_if.Grb, bus_if.Grc, bus_if.Rin, bus_if.Rout,
                  bus_if.BAout, bus_if.CON_in, bus_if.HIin, bus_if.LOin,
                  bus_if.Zhighin, bus_if.Zlowin, bus_if.PCin, bus_if.MDRin,
                  bus_if.OutPortin, bus_if.MARin, bus_if.IRin, bus_if.Yin,
                  bus_if.HIout, bus_if.LOout, bus_if.ZHIout, bus_if.ZLOout,
                  bus_if.PCout, bus_if.MDRout, bus_if.Inportout, bus_if.Cout,
                  bus_if.IncPC, bus_if.read, bus_if.write};

  localparam logic [33:0] WR   = 34'd1 << 0,  RD   = 34'd1 << 1,  INC  = 34'd1 << 2;
  localparam logic [33:0] COUT = 34'd1 << 3,  INPO = 34'd1 << 4,  MDRO = 34'd1 << 5;
  localparam logic [33:0] PCO  = 34'd1 << 6,  ZLO  = 34'd1 << 7,  ZHO  = 34'd1 << 8;
  localparam logic [33:0] LOO  = 34'd1 << 9,  HIO  = 34'd1 << 10, YIN  = 34'd1 << 11;
  localparam logic [33:0] IRI  = 34'd1 << 12, MARI = 34'd1 << 13, OPI  = 34'd1 << 14;
  localparam logic [33:0] MDRI = 34'd1 << 15, PCIN = 34'd1 << 16, ZLI  = 34'd1 << 17;
  localparam logic [33:0] ZHI  = 34'd1 << 18, LOI  = 34'd1 << 19, HII  = 34'd1 << 20;
  localparam logic [33:0] CONI = 34'd1 << 21, BAO  = 34'd1 << 22, ROUT = 34'd1 << 23;
  localparam logic [33:0] RIN  = 34'd1 << 24, GRC  = 34'd1 << 25, GRB  = 34'd1 << 26;
  localparam logic [33:0] GRA  = 34'd1 << 27, RUN  = 34'd1 << 28;

  localparam logic [33:0] F0V = RUN | PCO | MARI | INC;
  localparam logic [33:0] F1V = RUN | RD;
  localparam logic [33:0] F2V = RUN | RD | MDRI;
  localparam logic [33:0] F3V = RUN | MDRO | IRI;
  localparam logic [33:0] DNV = RUN;

  function automatic logic [33:0] opv(input logic [4:0] o);
    return {o, 29'd0};
  endfunction

  // Releases the sequencer from the post-instruction PAUSE in step mode.
  task automatic resume();
`ifdef CU_SINGLE_STEP_EN
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
`endif
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (w_obs !== 34'd0) begin failures++; $display("FAIL reset_hold got=%h exp=%h", w_obs, 34'd0); end
    @(negedge clock);
    checks++;
    if (w_obs !== 34'd0) begin failures++; $display("FAIL reset_hold2 got=%h exp=%h", w_obs, 34'd0); end
    clear = 1'b1;
    @(negedge clock);
    checks++;
    if (w_obs !== F0V) begin failures++; $display("FAIL reset_f0 got=%h exp=%h", w_obs, F0V); end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (w_obs !== F2V) begin failures++; $display("FAIL reset_f2 got=%h exp=%h", w_obs, F2V); end
    clear = 1'b0;
    #1;
    checks++;
    if (w_obs !== 34'd0) begin failures++; $display("FAIL reset_async got=%h exp=%h", w_obs, 34'd0); end
    @(negedge clock);
    checks++;
    if (w_obs !== 34'd0) begin failures++; $display("FAIL reset_held got=%h exp=%h", w_obs, 34'd0); end
    clear = 1'b1;
    @(negedge clock);
    checks++;
    if (w_obs !== F0V) begin failures++; $display("FAIL reset_release got=%h exp=%h", w_obs, F0V); end
  endtask

  task automatic test_add();
    logic [33:0] exp [$];
    bus_if.ir = 32'h19A28000;
    exp = '{F0V, F1V, F2V, F3V, RUN | GRB | ROUT | YIN,
            RUN | GRC | ROUT | ZLI | opv(5'd3), RUN | ZLO | GRA | RIN, DNV};
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (w_obs !== exp[i]) begin failures++; $display("FAIL add cyc%0d got=%h exp=%h", i, w_obs, exp[i]); end
      @(negedge clock);
    end
    resume();
  endtask

  task automatic test_andi();
    logic [33:0] exp [$];
    bus_if.ir = 32'h68000000;
    exp = '{F0V, F1V, F2V, F3V, RUN | GRB | ROUT | YIN,
            RUN | COUT | ZLI | opv(5'd13), RUN | ZLO | GRA | RIN, DNV};
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (w_obs !== exp[i]) begin failures++; $display("FAIL andi cyc%0d got=%h exp=%h", i, w_obs, exp[i]); end
      @(negedge clock);
    end
    resume();
  endtask

  task automatic test_ld();
    logic [33:0] exp [$];
    bus_if.ir = 32'h00000000;
    exp = '{F0V, F1V, F2V, F3V, RUN | GRB | BAO | YIN,
            RUN | COUT | ZLI | opv(5'd3), RUN | ZLO | MARI, RUN | RD,
            RUN | RD | MDRI, RUN | MDRO | GRA | RIN, DNV};
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (w_obs !== exp[i]) begin failures++; $display("FAIL ld cyc%0d got=%h exp=%h", i, w_obs, exp[i]); end
      @(negedge clock);
    end
    resume();
  endtask

  task automatic test_st();
    logic [33:0] exp [$];
    bus_if.ir = 32'h10000000;
    exp = '{F0V, F1V, F2V, F3V, RUN | GRB | BAO | YIN,
            RUN | COUT | ZLI | opv(5'd3), RUN | ZLO | MARI,
            RUN | GRA | ROUT | MDRI, RUN | WR, DNV};
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (w_obs !== exp[i]) begin failures++; $display("FAIL st cyc%0d got=%h exp=%h", i, w_obs, exp[i]); end
      @(negedge clock);
    end
    resume();
  endtask

  task automatic test_br(input logic con);
    logic [33:0] exp [$];
    bus_if.ir = 32'h98000000;
    bus_if.CON_out = con;
    exp = '{F0V, F1V, F2V, F3V, RUN | GRA | ROUT | CONI, RUN | PCO | YIN,
            RUN | COUT | ZLI | opv(5'd3), con ? (RUN | ZLO | PCIN) : RUN, DNV};
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (w_obs !== exp[i]) begin failures++; $display("FAIL br con=%0b cyc%0d got=%h exp=%h", con, i, w_obs, exp[i]); end
      @(negedge clock);
    end
    bus_if.CON_out = 1'b0;
    resume();
  endtask

  task automatic test_nop(input logic [31:0] instr);
    logic [33:0] exp [$];
    bus_if.ir = instr;
    exp = '{F0V, F1V, F2V, F3V, DNV};
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (w_obs !== exp[i]) begin failures++; $display("FAIL nop ir=%h cyc%0d got=%h exp=%h", instr, i, w_obs, exp[i]); end
      @(negedge clock);
    end
    resume();
  endtask

  task automatic test_jal();
    logic [33:0] exp [$];
    bus_if.ir = 32'hA8000000;
    exp = '{F0V, F1V, F2V, F3V, RUN | PCO | GRB | RIN, RUN | GRA | ROUT | PCIN, DNV};
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (w_obs !== exp[i]) begin failures++; $display("FAIL jal cyc%0d got=%h exp=%h", i, w_obs, exp[i]); end
      @(negedge clock);
    end
    resume();
  endtask

  task automatic test_stop_mul();
    logic [33:0] exp [$];
    bus_if.ir = 32'h80000000;
    exp = '{F0V, F1V, F2V, F3V, RUN | GRA | ROUT | YIN,
            RUN | GRB | ROUT | ZHI | ZLI | opv(5'd16), RUN | ZLO | LOI,
            RUN | ZHO | HII, DNV};
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (w_obs !== exp[i]) begin failures++; $display("FAIL mul_stop cyc%0d got=%h exp=%h", i, w_obs, exp[i]); end
      if (i == 5) bus_if.stop = 1'b1;
      @(negedge clock);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (w_obs !== 34'd0) begin failures++; $display("FAIL pause cyc%0d got=%h exp=%h", i, w_obs, 34'd0); end
      @(negedge clock);
    end
    bus_if.stop = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    step = 1'b1;
`endif
    @(negedge clock);
`ifdef CU_SINGLE_STEP_EN
    step = 1'b0;
`endif
    checks++;
    if (w_obs !== F0V) begin failures++; $display("FAIL pause_exit got=%h exp=%h", w_obs, F0V); end
  endtask

  task automatic test_halt();
    logic [33:0] exp [$];
    bus_if.ir = 32'hD8000000;
    exp = '{F0V, F1V, F2V, F3V, RUN};
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (w_obs !== exp[i]) begin failures++; $display("FAIL halt_seq cyc%0d got=%h exp=%h", i, w_obs, exp[i]); end
      @(negedge clock);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (w_obs !== 34'd0) begin failures++; $display("FAIL halt_hold cyc%0d got=%h exp=%h", i, w_obs, 34'd0); end
      if (i == 1) bus_if.stop = 1'b1;
      if (i == 2) bus_if.stop = 1'b0;
      @(negedge clock);
    end
  endtask

`ifdef CU_SINGLE_STEP_EN
  task automatic test_step();
    logic [33:0] exp [$];
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    bus_if.ir = 32'hD0000000;
    exp = '{F0V, F1V, F2V, F3V, DNV, 34'd0, 34'd0};
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (w_obs !== exp[i]) begin failures++; $display("FAIL step_first cyc%0d got=%h exp=%h", i, w_obs, exp[i]); end
      @(negedge clock);
    end
    step = 1'b1;
    @(negedge clock);
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (w_obs !== exp[i]) begin failures++; $display("FAIL step_one cyc%0d got=%h exp=%h", i, w_obs, exp[i]); end
      @(negedge clock);
    end
    step = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.ir = 32'h19A28000;
    bus_if.CON_out = 1'b0;
    bus_if.stop = 1'b0;
    test_reset();
    test_add();
    test_andi();
    test_ld();
    test_st();
    test_br(1'b1);
    test_br(1'b0);
    test_nop(32'hD0000000);
    test_nop(32'hF8000000);
    test_jal();
    test_stop_mul();
    test_halt();
`ifdef CU_SINGLE_STEP_EN
    test_step();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
